// File: rtl/dphy_lp_seq_rx.sv
`default_nettype none
// ============================================================================
// Module   : dphy_lp_seq_rx
// Brief    : Per-lane D-PHY LP glitch filter, SoT/EoT sequence tracker and
//            HS-settle masker with registered all-lanes-valid flag.
// Revision : 1.0 - initial release
// ============================================================================
module dphy_lp_seq_rx #(
  parameter int LANES        = 4,
  parameter int T_SETTLE     = 300_000,
  parameter int T_CLK        = 5_000,
  parameter int FILTER_TICKS = 2
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic [LANES-1:0] lp_data_p_i,
  input  logic [LANES-1:0] lp_data_n_i,
  output logic [LANES-1:0] hs_data_valid_o,
  output logic             all_lanes_valid_o,
  output logic [LANES-1:0] sot_o,
  output logic [LANES-1:0] eot_o,
  output logic [LANES-1:0] lp_err_o
);

  localparam int IGNORE_TICKS = T_SETTLE / T_CLK;
  localparam int SCNT_W_RAW   = $clog2(IGNORE_TICKS + 1);
  localparam int SCNT_W       = (SCNT_W_RAW > 0) ? SCNT_W_RAW : 1;
  localparam int FCNT_W       = (FILTER_TICKS > 1) ? $clog2(FILTER_TICKS) : 1;

  localparam logic [SCNT_W-1:0] SETTLE_LAST = SCNT_W'(IGNORE_TICKS - 1);
  localparam logic [FCNT_W-1:0] FILT_LAST   = FCNT_W'(FILTER_TICKS - 1);

  localparam logic [1:0] LP_00 = 2'b00;
  localparam logic [1:0] LP_01 = 2'b01;
  localparam logic [1:0] LP_10 = 2'b10;
  localparam logic [1:0] LP_11 = 2'b11;

  if (IGNORE_TICKS < 1) begin : g_bad_settle
    $error("dphy_lp_seq_rx: T_SETTLE / T_CLK must be at least 1");
  end
  if (FILTER_TICKS < 1) begin : g_bad_filter
    $error("dphy_lp_seq_rx: FILTER_TICKS must be at least 1");
  end
  if (LANES < 1 || LANES > 4) begin : g_bad_lanes
    $error("dphy_lp_seq_rx: LANES must be in 1..4");
  end

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LP11 = 3'd1,
    ST_LP01 = 3'd2,
    ST_LP00 = 3'd3,
    ST_HS   = 3'd4
  } lane_state_t;

  logic [LANES-1:0] hs_next;
  logic             all_valid_q;
  logic             all_valid_d;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [1:0]        lp_raw;
    logic [1:0]        smp_q, smp_d;
    logic [FCNT_W-1:0] stab_q, stab_d;
    logic [1:0]        f_q, f_d;
    lane_state_t       state_q, state_d;
    logic [SCNT_W-1:0] settle_q, settle_d;
    logic              err_d;
    logic              hs_valid_q, hs_valid_d;
    logic              sot_q, sot_d;
    logic              eot_q, eot_d;
    logic              err_q;

    assign lp_raw = {lp_data_p_i[l], lp_data_n_i[l]};

    // f only follows a sample that has already matched for FILTER_TICKS edges.
    always_comb begin
      smp_d  = lp_raw;
      stab_d = stab_q;
      f_d    = f_q;
      if (lp_raw != smp_q) begin
        stab_d = '0;
      end else if (stab_q != FILT_LAST) begin
        stab_d = stab_q + 1'b1;
      end
      if (stab_q == FILT_LAST) begin
        f_d = smp_q;
      end
    end

    always_comb begin
      state_d = state_q;
      err_d   = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (f_q == LP_11) state_d = ST_LP11;
        end
        ST_LP11: begin
          if (f_q == LP_01) begin
            state_d = ST_LP01;
          end else if (f_q != LP_11) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end
        end
        ST_LP01: begin
          if (f_q == LP_00) begin
            state_d = ST_LP00;
          end else if (f_q == LP_11) begin
            state_d = ST_LP11;
          end else if (f_q == LP_10) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end
        end
        ST_LP00: begin
          // A line change wins over settle expiry in the same cycle.
          if (f_q == LP_11) begin
            state_d = ST_LP11;
            err_d   = 1'b1;
          end else if (f_q != LP_00) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end else if (settle_q == SETTLE_LAST) begin
            state_d = ST_HS;
          end
        end
        ST_HS: begin
          if (f_q == LP_11) state_d = ST_LP11;
        end
        default: state_d = ST_IDLE;
      endcase

      settle_d = '0;
      if (state_q == ST_LP00 && state_d == ST_LP00) begin
        settle_d = settle_q + 1'b1;
      end

      hs_valid_d = (state_d == ST_HS);
      sot_d      = (state_d == ST_HS) && (state_q != ST_HS);
      eot_d      = (state_q == ST_HS) && (state_d != ST_HS);
    end

    always_ff @(posedge clk_i or posedge srst_i) begin
      if (srst_i) begin
        smp_q      <= LP_00;
        stab_q     <= '0;
        f_q        <= LP_00;
        state_q    <= ST_IDLE;
        settle_q   <= '0;
        hs_valid_q <= 1'b0;
        sot_q      <= 1'b0;
        eot_q      <= 1'b0;
        err_q      <= 1'b0;
      end else begin
        smp_q      <= smp_d;
        stab_q     <= stab_d;
        f_q        <= f_d;
        state_q    <= state_d;
        settle_q   <= settle_d;
        hs_valid_q <= hs_valid_d;
        sot_q      <= sot_d;
        eot_q      <= eot_d;
        err_q      <= err_d;
      end
    end

    assign hs_next[l]         = (state_d == ST_HS);
    assign hs_data_valid_o[l] = hs_valid_q;
    assign sot_o[l]           = sot_q;
    assign eot_o[l]           = eot_q;
    assign lp_err_o[l]        = err_q;
  end

  // Registered from next-state so it lines up with the per-lane valid flops.
  assign all_valid_d = &hs_next;

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      all_valid_q <= 1'b0;
    end else begin
      all_valid_q <= all_valid_d;
    end
  end

  assign all_lanes_valid_o = all_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_dphy_lp_seq_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_dphy_lp_seq_rx
// Brief    : Self-checking bench for dphy_lp_seq_rx (vector table, corner
//            sequences and randomized traffic against a reference model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dphy_lp_seq_rx;
  localparam int L       = 4;
  localparam int FT      = 2;
  localparam int IGN     = 300_000 / 5_000;
  localparam int SOT_LAT = FT + 1 + IGN;

  logic         clk = 1'b0;
  logic         srst = 1'b0;
  logic [L-1:0] lp_p = '0;
  logic [L-1:0] lp_n = '0;
  logic [L-1:0] hs_o, sot_o, eot_o, err_o;
  logic         all_o;

  always #5 clk = ~clk;

  dphy_lp_seq_rx #(
    .LANES(L), .T_SETTLE(300_000), .T_CLK(5_000), .FILTER_TICKS(FT)
  ) dut (
    .clk_i(clk), .srst_i(srst),
    .lp_data_p_i(lp_p), .lp_data_n_i(lp_n),
    .hs_data_valid_o(hs_o), .all_lanes_valid_o(all_o),
    .sot_o(sot_o), .eot_o(eot_o), .lp_err_o(err_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: progress through the SoT word list plus a timestamp of
  // LP-00 entry; the filter looks at the last FT raw samples directly.
  logic [1:0]   sot_seq [3] = '{2'b11, 2'b01, 2'b00};
  int           m_k;
  int           m_pos  [L];   // -1 idle, 0..2 index into sot_seq, 3 HS
  int           m_tent [L];
  logic [1:0]   m_f    [L];
  logic [1:0]   m_hist [L][8];
  int           m_ns   [L];
  logic [L-1:0] e_hs, e_sot, e_eot, e_err;
  logic         e_all;

  task automatic model_reset();
    m_k = 0;
    for (int l = 0; l < L; l++) begin
      m_pos[l]  = -1;
      m_tent[l] = 0;
      m_f[l]    = 2'b00;
      for (int j = 0; j < 8; j++) m_hist[l][j] = 2'b00;
      m_ns[l]   = 1;
    end
    e_hs = '0; e_sot = '0; e_eot = '0; e_err = '0; e_all = 1'b0;
  endtask

  task automatic model_edge(input logic [L-1:0] p, input logic [L-1:0] n);
    m_k++;
    for (int l = 0; l < L; l++) begin
      int         np;
      bit         er;
      bit         stable;
      logic [1:0] f;
      f  = m_f[l];
      np = m_pos[l];
      er = 1'b0;
      if (m_pos[l] == 3) begin
        if (f == 2'b11) np = 0;
      end else if (f == 2'b11) begin
        np = 0;
        er = (m_pos[l] == 2);
      end else if (m_pos[l] >= 0) begin
        if (m_pos[l] < 2 && f == sot_seq[m_pos[l] + 1]) begin
          np = m_pos[l] + 1;
          if (np == 2) m_tent[l] = m_k;
        end else if (f == sot_seq[m_pos[l]]) begin
          if (m_pos[l] == 2 && (m_k - m_tent[l]) == IGN) np = 3;
        end else begin
          np = -1;
          er = 1'b1;
        end
      end
      stable = (m_ns[l] >= FT);
      for (int j = 1; j < FT; j++) if (m_hist[l][j] != m_hist[l][0]) stable = 1'b0;
      if (stable) m_f[l] = m_hist[l][0];
      for (int j = 7; j > 0; j--) m_hist[l][j] = m_hist[l][j-1];
      m_hist[l][0] = {p[l], n[l]};
      if (m_ns[l] < 8) m_ns[l]++;
      e_hs[l]  = (np == 3);
      e_sot[l] = (np == 3) && (m_pos[l] != 3);
      e_eot[l] = (m_pos[l] == 3) && (np != 3);
      e_err[l] = er;
      m_pos[l] = np;
    end
    e_all = &e_hs;
  endtask

  task automatic chk(input string nm, input logic [L-1:0] act, input logic [L-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %b, expected %b", nm, m_k, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got edge %0d, expected edge %0d", nm, act, exp);
    end
  endtask

  task automatic chk_model();
    chk("hs_valid", hs_o, e_hs);
    chk("sot", sot_o, e_sot);
    chk("eot", eot_o, e_eot);
    chk("lp_err", err_o, e_err);
    chk("all_valid", L'(all_o), L'(e_all));
  endtask

  task automatic step(input logic [L-1:0] p, input logic [L-1:0] n);
    lp_p = p;
    lp_n = n;
    @(posedge clk);
    #1;
    model_edge(p, n);
    chk_model();
    @(negedge clk);
  endtask

  task automatic step_all(input logic [1:0] r);
    step({L{r[1]}}, {L{r[0]}});
  endtask

  // Asserted between edges so the async clear is observed before any edge.
  task automatic do_reset(input int edges);
    srst = 1'b1;
    #1;
    model_reset();
    chk_model();
    repeat (edges) @(posedge clk);
    @(negedge clk);
    srst = 1'b0;
  endtask

  typedef struct {
    logic [1:0] raw;
    int         reps;
    logic       hs;
    logic       sot;
    logic       eot;
    logic       err;
  } vec_t;

  vec_t       tbl [14];
  int         rise [L];
  int         all_rise, fall, afall, e0;
  int         r_step [L];
  int         r_left [L];
  logic [1:0] r_val  [L];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // raw, reps, then hs/sot/eot/err expected after the last edge of the row
    tbl[0]  = '{2'b11,  5, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{2'b10,  1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{2'b11,  4, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{2'b10,  4, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{2'b10,  1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{2'b11,  5, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{2'b01,  5, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{2'b00, 62, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{2'b00,  1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{2'b00,  1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{2'b00,  1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{2'b11,  3, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{2'b11,  1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{2'b11,  1, 1'b0, 1'b0, 1'b0, 1'b0};

    #1 srst = 1'b1;
    @(negedge clk);
    do_reset(2);

    for (int i = 0; i < 14; i++) begin
      repeat (tbl[i].reps) step_all(tbl[i].raw);
      chk("tbl_hs", hs_o, {L{tbl[i].hs}});
      chk("tbl_sot", sot_o, {L{tbl[i].sot}});
      chk("tbl_eot", eot_o, {L{tbl[i].eot}});
      chk("tbl_err", err_o, {L{tbl[i].err}});
      chk("tbl_all", L'(all_o), L'(tbl[i].hs));
    end

    // Lane skew: lane l starts LP-00 l edges after lane 0.
    do_reset(2);
    repeat (5) step_all(2'b11);
    repeat (5) step_all(2'b01);
    e0 = m_k + 1;
    for (int l = 0; l < L; l++) rise[l] = -1;
    all_rise = -1;
    for (int i = 0; i < 75; i++) begin
      logic [L-1:0] z;
      for (int l = 0; l < L; l++) z[l] = (i >= l);
      step('0, ~z);
      for (int l = 0; l < L; l++) if (rise[l] < 0 && hs_o[l]) rise[l] = m_k;
      if (all_rise < 0 && all_o) all_rise = m_k;
    end
    for (int l = 0; l < L; l++) chk_int("skew_rise", rise[l], e0 + SOT_LAT + l);
    chk_int("skew_all_rise", all_rise, e0 + SOT_LAT + L - 1);

    // Lane 1 leaves HS; the merged flag must fall on the same edge.
    e0 = m_k + 1;
    fall = -1;
    afall = -1;
    for (int i = 0; i < 8; i++) begin
      step(L'(2), L'(2));
      if (fall < 0 && !hs_o[1]) fall = m_k;
      if (afall < 0 && !all_o) afall = m_k;
    end
    chk_int("l1_fall", fall, e0 + FT + 1);
    chk_int("all_fall", afall, e0 + FT + 1);

    // Lane 1 re-enters HS with a fresh 01/00 sequence.
    repeat (5) step('0, L'(2));
    e0 = m_k + 1;
    rise[1] = -1;
    all_rise = -1;
    for (int i = 0; i < 70; i++) begin
      step('0, '0);
      if (rise[1] < 0 && hs_o[1]) rise[1] = m_k;
      if (all_rise < 0 && all_o) all_rise = m_k;
    end
    chk_int("l1_reenter", rise[1], e0 + SOT_LAT);
    chk_int("all_reenter", all_rise, e0 + SOT_LAT);

    // Reset 30 cycles into LP-00, then again while in HS.
    do_reset(2);
    repeat (5) step_all(2'b11);
    repeat (5) step_all(2'b01);
    repeat (FT + 1 + 30) step_all(2'b00);
    do_reset(3);
    repeat (5) step_all(2'b11);
    repeat (5) step_all(2'b01);
    e0 = m_k + 1;
    rise[0] = -1;
    for (int i = 0; i < 70; i++) begin
      step_all(2'b00);
      if (rise[0] < 0 && hs_o[0]) rise[0] = m_k;
    end
    chk_int("post_reset_sot", rise[0], e0 + SOT_LAT);
    do_reset(2);
    repeat (4) step_all(2'b00);

    // Randomized traffic: mostly well-formed SoT attempts of random timing,
    // mixed with random line values and occasional resets.
    do_reset(2);
    for (int l = 0; l < L; l++) begin
      r_step[l] = -1;
      r_left[l] = 0;
      r_val[l]  = 2'b11;
    end
    for (int c = 0; c < 4000; c++) begin
      logic [L-1:0] p, n;
      for (int l = 0; l < L; l++) begin
        if (r_left[l] == 0) begin
          if (r_step[l] >= 0 && r_step[l] <= 2) begin
            r_step[l]++;
            case (r_step[l])
              1:       begin r_val[l] = 2'b01; r_left[l] = $urandom_range(1, 4);   end
              2:       begin r_val[l] = 2'b00; r_left[l] = $urandom_range(50, 90); end
              default: begin r_val[l] = 2'b11; r_left[l] = $urandom_range(1, 3);   end
            endcase
          end else if ($urandom_range(0, 99) < 55) begin
            r_step[l] = 0;
            r_val[l]  = 2'b11;
            r_left[l] = $urandom_range(1, 4);
          end else begin
            r_step[l] = -1;
            r_val[l]  = 2'($urandom_range(0, 3));
            r_left[l] = $urandom_range(1, 3);
          end
        end
        r_left[l]--;
        p[l] = r_val[l][1];
        n[l] = r_val[l][0];
      end
      if ($urandom_range(0, 999) == 0) do_reset($urandom_range(1, 3));
      step(p, n);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
